// File: rtl/adc_spi_cmd_queue.sv
// adc_spi_cmd_queue
// Command queue in front of the ADC/DAC SPI wrapper. Host register writes
// (7-bit slave address + 32-bit data) are buffered in a FIFO and drained one
// transaction at a time, with a programmable idle gap between transactions
// and sticky error flags for dropped writes and lost commands.
//
// Handshake with the SPI engine: o_enable is a single-cycle request and
// o_addr/o_data are stable from that cycle until the next request. The engine
// acknowledges by raising i_spi_busy and completes by dropping it. A request
// counts as lost if busy does not rise within START_TIMEOUT clocks. A new
// request is never made while busy is high or during the gap.
module adc_spi_cmd_queue #(
    parameter int  DEPTH         = 16,
    parameter int  GAP_CYCLES    = 8,
    parameter int  START_TIMEOUT = 15,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic          i_clock,
    input  logic          i_reset,        // asynchronous, active-low
    input  logic          i_wr_en,
    input  logic [6:0]    i_wr_addr,
    input  logic [31:0]   i_wr_data,
    output logic          o_full,
    output logic [AW:0]   o_level,
    output logic          o_enable,
    output logic [6:0]    o_addr,
    output logic [31:0]   o_data,
    input  logic          i_spi_busy,
    output logic          o_idle,
    output logic          o_done,
    output logic          o_overflow,
    output logic          o_timeout_err,
    input  logic          i_clear_err,
    output logic [2:0]    o_dbg_state
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ISSUE      = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_GAP        = 3'd4;

    // With no gap configured a finished transaction returns straight to IDLE.
    localparam logic [2:0]    S_AFTER  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [15:0]   CNT_ONE  = 16'd1;
    localparam logic [15:0]   TO_LAST  = 16'(START_TIMEOUT - 1);
    localparam logic [15:0]   GAP_LAST = 16'(GAP_CYCLES - 1);

    logic [38:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_full;
    logic [2:0]    r_state;
    logic [15:0]   r_cnt;
    logic          r_enable;
    logic          r_done;
    logic [6:0]    r_addr;
    logic [31:0]   r_data;
    logic          r_idle;
    logic          r_overflow;
    logic          r_timeout_err;

    logic          w_push;
    logic          w_pop;
    logic          w_overflow_set;
    logic          w_timeout_set;
    logic [AW:0]   w_level_next;
    logic [38:0]   w_head;

    // A write is accepted only when not full; the pop belongs to ISSUE, which
    // is entered only with a non-empty FIFO.
    assign w_push         = i_wr_en && !r_full;
    assign w_pop          = (r_state == S_ISSUE);
    assign w_overflow_set = i_wr_en && r_full;
    assign w_timeout_set  = (r_state == S_WAIT_START) && !i_spi_busy &&
                            (r_cnt == TO_LAST);
    assign w_head         = r_mem[r_rd_ptr];

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - LVL_ONE;
        end
    end

    // FIFO storage: written on accepted pushes, no reset needed.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_wr_addr, i_wr_data};
        end
    end

    // FIFO pointers, level and full flag; pointers wrap modulo DEPTH.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level <= w_level_next;
            r_full  <= (w_level_next == LVL_FULL);
        end
    end

    // Transaction sequencer: issue, wait for busy to rise, wait for it to
    // fall, then hold off for the inter-command gap.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_level != '0) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_addr   <= w_head[38:32];
                    r_data   <= w_head[31:0];
                    r_enable <= 1'b1;
                    r_cnt    <= '0;
                    r_state  <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (i_spi_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        // Command lost: no done pulse, still observe the gap.
                        r_cnt   <= '0;
                        r_state <= S_AFTER;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_spi_busy) begin
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_AFTER;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered idle indication built from the current level and state.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_idle <= 1'b1;
        end else begin
            r_idle <= (r_level == '0) && (r_state == S_IDLE);
        end
    end

    // Sticky error flags; a set event in the same cycle as a clear wins.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end else if (i_clear_err) begin
                r_overflow <= 1'b0;
            end
            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end else if (i_clear_err) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign o_full        = r_full;
    assign o_level       = r_level;
    assign o_enable      = r_enable;
    assign o_addr        = r_addr;
    assign o_data        = r_data;
    assign o_idle        = r_idle;
    assign o_done        = r_done;
    assign o_overflow    = r_overflow;
    assign o_timeout_err = r_timeout_err;
    assign o_dbg_state   = r_state;

endmodule
